apb2ahb_bridge_param: RTL and testbench

Parametrised single-clock APB3 slave to AHB-Lite master bridge. It forwards one APB transfer as one AHB SINGLE/NONSEQ transfer and holds APB PREADY low through AHB wait states. AHB error responses are returned on PSLVERR, and an optional bus timeout ends a hung transfer. Sits between the APB peripheral fabric and an AHB-Lite slave. HCLK is PCLK.

---
 rtl/apb2ahb_bridge_param.sv | 193 +++++++++++++++++++
 tb/tb_apb2ahb_bridge_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2ahb_bridge_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : apb2ahb_bridge_param
//  Purpose  : APB3 slave to AHB-Lite master bridge, one APB access forwarded
//             as one AHB SINGLE/NONSEQ transfer. Optional hung-bus timeout
//             enabled by defining APB2AHB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module apb2ahb_bridge_param #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic              HSEL,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] c_hsize   = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] c_idle    = 2'b00;
    localparam logic [1:0] c_nonseq  = 2'b10;

    state_t              r_state,   w_state_nxt;
    logic [ADDR_W-1:0]   r_haddr,   w_haddr_nxt;
    logic                r_hwrite,  w_hwrite_nxt;
    logic [1:0]          r_htrans,  w_htrans_nxt;
    logic                r_hsel,    w_hsel_nxt;
    logic [DATA_W-1:0]   r_hwdata,  w_hwdata_nxt;
    logic [DATA_W-1:0]   r_wdata,   w_wdata_nxt;
    logic [DATA_W-1:0]   r_prdata,  w_prdata_nxt;
    logic                r_pready,  w_pready_nxt;
    logic                r_pslverr, w_pslverr_nxt;
    logic                w_tmo_hit;

`ifdef APB2AHB_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_tmo_cnt;

    // Counts HREADY-low cycles of the current AHB transfer only.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == ST_IDLE && w_state_nxt == ST_ADDR) begin
            r_tmo_cnt <= 16'd0;
        end else if ((r_state == ST_ADDR || r_state == ST_DATA) && !HREADY) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_tmo_hit = !HREADY && (r_tmo_cnt == c_tmo_last);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_haddr_nxt   = r_haddr;
        w_hwrite_nxt  = r_hwrite;
        w_htrans_nxt  = r_htrans;
        w_hsel_nxt    = r_hsel;
        w_hwdata_nxt  = r_hwdata;
        w_wdata_nxt   = r_wdata;
        w_prdata_nxt  = r_prdata;
        w_pready_nxt  = r_pready;
        w_pslverr_nxt = r_pslverr;

        case (r_state)
            ST_IDLE: begin
                // Only the APB setup phase starts a transfer.
                if (PSEL && !PENABLE) begin
                    w_haddr_nxt  = PADDR;
                    w_wdata_nxt  = PWDATA;
                    w_hwrite_nxt = PWRITE;
                    w_htrans_nxt = c_nonseq;
                    w_hsel_nxt   = 1'b1;
                    w_state_nxt  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    w_htrans_nxt = c_idle;
                    w_hsel_nxt   = 1'b0;
                    w_hwdata_nxt = r_wdata;
                    w_state_nxt  = ST_DATA;
                end else if (w_tmo_hit) begin
                    w_htrans_nxt  = c_idle;
                    w_hsel_nxt    = 1'b0;
                    w_pslverr_nxt = 1'b1;
                    w_pready_nxt  = 1'b1;
                    w_prdata_nxt  = '0;
                    w_state_nxt   = ST_RESP;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    if (!HRESP && !r_hwrite) begin
                        w_prdata_nxt = HRDATA;
                    end
                    w_pslverr_nxt = HRESP;
                    w_pready_nxt  = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else if (w_tmo_hit) begin
                    w_htrans_nxt  = c_idle;
                    w_hsel_nxt    = 1'b0;
                    w_pslverr_nxt = 1'b1;
                    w_pready_nxt  = 1'b1;
                    w_prdata_nxt  = '0;
                    w_state_nxt   = ST_RESP;
                end
            end
            ST_RESP: begin
                w_pready_nxt  = 1'b0;
                w_pslverr_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_haddr   <= '0;
            r_hwrite  <= 1'b0;
            r_htrans  <= c_idle;
            r_hsel    <= 1'b0;
            r_hwdata  <= '0;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_haddr   <= w_haddr_nxt;
            r_hwrite  <= w_hwrite_nxt;
            r_htrans  <= w_htrans_nxt;
            r_hsel    <= w_hsel_nxt;
            r_hwdata  <= w_hwdata_nxt;
            r_wdata   <= w_wdata_nxt;
            r_prdata  <= w_prdata_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
        end
    end

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign HADDR   = r_haddr;
    assign HWRITE  = r_hwrite;
    assign HTRANS  = r_htrans;
    assign HSIZE   = c_hsize;
    assign HBURST  = 3'b000;
    assign HSEL    = r_hsel;
    assign HWDATA  = r_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb2ahb_bridge_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_apb2ahb_bridge_param
//  Purpose  : Directed self-checking bench for apb2ahb_bridge_param (64-bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb2ahb_bridge_param;

    localparam int c_addr_w = 32;
    localparam int c_data_w = 64;

    logic                PCLK;
    logic                PRESETn;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [c_addr_w-1:0] PADDR;
    logic [c_data_w-1:0] PWDATA;
    logic [c_data_w-1:0] PRDATA;
    logic                PREADY;
    logic                PSLVERR;
    logic [c_addr_w-1:0] HADDR;
    logic                HWRITE;
    logic [1:0]          HTRANS;
    logic [2:0]          HSIZE;
    logic [2:0]          HBURST;
    logic                HSEL;
    logic [c_data_w-1:0] HWDATA;
    logic [c_data_w-1:0] HRDATA;
    logic                HREADY;
    logic                HRESP;

    int r_cyc;
    int n_pass;
    int n_total;

    apb2ahb_bridge_param #(
        .ADDR_W         (c_addr_w),
        .DATA_W         (c_data_w),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .HADDR   (HADDR),
        .HWRITE  (HWRITE),
        .HTRANS  (HTRANS),
        .HSIZE   (HSIZE),
        .HBURST  (HBURST),
        .HSEL    (HSEL),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .HREADY  (HREADY),
        .HRESP   (HRESP)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial r_cyc = 0;
    always @(posedge PCLK) r_cyc <= r_cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic setup(input logic wr, input logic [31:0] addr, input logic [63:0] data);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
    endtask

    task automatic apb_idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    int t1;
    int t2;
    logic seen;

    initial begin
        n_pass  = 0;
        n_total = 0;
        PRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        tick(); tick();
        PRESETn = 1'b1;
        tick();

        // Reset state and constant outputs
        check("rst_pready", {63'd0, PREADY}, 64'd0);
        check("rst_htrans", {62'd0, HTRANS}, 64'd0);
        check("rst_hsel",   {63'd0, HSEL},   64'd0);
        check("rst_prdata", PRDATA, 64'd0);
        check("hsize",      {61'd0, HSIZE},  64'd3);
        check("hburst",     {61'd0, HBURST}, 64'd0);

        // Zero-wait write
        setup(1'b1, 32'h1000, 64'hDEADBEEF);
        tick();
        check("w_addr_htrans", {62'd0, HTRANS}, 64'd2);
        check("w_addr_hsel",   {63'd0, HSEL},   64'd1);
        check("w_addr_haddr",  {32'd0, HADDR},  64'h1000);
        check("w_addr_hwrite", {63'd0, HWRITE}, 64'd1);
        PENABLE = 1'b1;
        PADDR   = 32'hFFFF;
        tick();
        check("w_data_htrans", {62'd0, HTRANS}, 64'd0);
        check("w_data_hwdata", HWDATA, 64'hDEADBEEF);
        check("w_data_pready", {63'd0, PREADY}, 64'd0);
        tick();
        check("w_resp_pready",  {63'd0, PREADY},  64'd1);
        check("w_resp_pslverr", {63'd0, PSLVERR}, 64'd0);
        tick();
        check("w_end_pready", {63'd0, PREADY}, 64'd0);
        apb_idle();

        // Read with two HREADY-low data-phase cycles
        tick();
        setup(1'b0, 32'h1004, 64'd0);
        tick();
        PENABLE = 1'b1;
        tick();
        HREADY = 1'b0;
        HRDATA = 64'h1111;
        tick();
        check("r_wait1_pready", {63'd0, PREADY}, 64'd0);
        tick();
        check("r_wait2_pready", {63'd0, PREADY}, 64'd0);
        HREADY = 1'b1;
        HRDATA = 64'hCAFEF00D;
        tick();
        check("r_pready", {63'd0, PREADY}, 64'd1);
        check("r_prdata", PRDATA, 64'hCAFEF00D);
        apb_idle();
        HRDATA = 64'h2222;
        tick();
        check("r_end_pready", {63'd0, PREADY}, 64'd0);
        check("r_prdata_hold", PRDATA, 64'hCAFEF00D);

        // Two-cycle ERROR on a write; APB master drops PSEL mid-transfer
        setup(1'b1, 32'h2000, 64'h55);
        tick();
        PENABLE = 1'b1;
        tick();
        apb_idle();
        PADDR  = 32'h9999;
        HREADY = 1'b0;
        HRESP  = 1'b1;
        tick();
        check("e_first_pready", {63'd0, PREADY}, 64'd0);
        HREADY = 1'b1;
        tick();
        check("e_pready",  {63'd0, PREADY},  64'd1);
        check("e_pslverr", {63'd0, PSLVERR}, 64'd1);
        check("e_prdata",  PRDATA, 64'hCAFEF00D);
        check("e_haddr",   {32'd0, HADDR}, 64'h2000);
        HRESP = 1'b0;
        tick();
        check("e_end_pready",  {63'd0, PREADY},  64'd0);
        check("e_end_pslverr", {63'd0, PSLVERR}, 64'd0);

        // Hung AHB slave
        setup(1'b0, 32'h3000, 64'd0);
        tick();
        PENABLE = 1'b1;
        HREADY  = 1'b0;
`ifdef APB2AHB_TIMEOUT_EN
        tick(); tick(); tick();
        check("t_pre_pready", {63'd0, PREADY}, 64'd0);
        check("t_pre_htrans", {62'd0, HTRANS}, 64'd2);
        tick();
        check("t_pready",  {63'd0, PREADY},  64'd1);
        check("t_pslverr", {63'd0, PSLVERR}, 64'd1);
        check("t_prdata",  PRDATA, 64'd0);
        check("t_htrans",  {62'd0, HTRANS}, 64'd0);
        check("t_hsel",    {63'd0, HSEL},   64'd0);
        apb_idle();
        HREADY = 1'b1;
        tick();
        check("t_end_pready", {63'd0, PREADY}, 64'd0);
`else
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (PREADY) seen = 1'b1;
        end
        check("t_no_pready", {63'd0, seen}, 64'd0);
        check("t_hold_htrans", {62'd0, HTRANS}, 64'd2);
        HREADY = 1'b1;
        HRDATA = 64'h77;
        tick();
        tick();
        check("t_pready",  {63'd0, PREADY},  64'd1);
        check("t_pslverr", {63'd0, PSLVERR}, 64'd0);
        check("t_prdata",  PRDATA, 64'h77);
        apb_idle();
        tick();
`endif

        // Reset asserted during a read data phase
        setup(1'b0, 32'h4000, 64'h1234);
        tick();
        PENABLE = 1'b1;
        tick();
        HREADY = 1'b0;
        tick();
        #2;
        PRESETn = 1'b0;
        #1;
        check("rs_htrans", {62'd0, HTRANS}, 64'd0);
        check("rs_hsel",   {63'd0, HSEL},   64'd0);
        check("rs_haddr",  {32'd0, HADDR},  64'd0);
        check("rs_hwdata", HWDATA, 64'd0);
        check("rs_prdata", PRDATA, 64'd0);
        check("rs_pready", {63'd0, PREADY}, 64'd0);
        apb_idle();
        HREADY = 1'b1;
        tick();
        #2;
        PRESETn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (PREADY) seen = 1'b1;
        end
        check("rs_no_pready", {63'd0, seen}, 64'd0);

        // Back-to-back write then read
        setup(1'b1, 32'h5000, 64'h0123456789ABCDEF);
        tick();
        PENABLE = 1'b1;
        tick();
        check("b_hwdata", HWDATA, 64'h0123456789ABCDEF);
        tick();
        check("b_w_pready", {63'd0, PREADY}, 64'd1);
        t1 = r_cyc;
        tick();
        setup(1'b0, 32'h5008, 64'd0);
        HRDATA = 64'hFEDCBA9876543210;
        tick();
        check("b_r_hwrite", {63'd0, HWRITE}, 64'd0);
        check("b_r_haddr",  {32'd0, HADDR},  64'h5008);
        PENABLE = 1'b1;
        tick();
        tick();
        check("b_r_pready", {63'd0, PREADY}, 64'd1);
        t2 = r_cyc;
        check("b_spacing", 64'(t2 - t1), 64'd4);
        check("b_r_prdata", PRDATA, 64'hFEDCBA9876543210);
        apb_idle();
        tick();
        check("b_end_pready", {63'd0, PREADY}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
